// File: rtl/l1_tlb_refill_ctrl.sv
// l1_tlb_refill_ctrl: L1 TLB miss sequencer with PTW handshake, victim choice and valid/PLRU ownership
module l1_tlb_refill_ctrl #(
  parameter int ENTRIES = 8,
  parameter int VPN_W = 27,
  parameter int ASID_W = 7,
  localparam int IW = $clog2(ENTRIES),
  localparam int TW = ASID_W + VPN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [VPN_W-1:0]  io_req_bits_vpn,
  input  logic [ASID_W-1:0] io_ptw_ptbr_asid,
  input  logic              tlb_miss,
  input  logic [ENTRIES-1:0] hits,
  output logic              io_ptw_req_valid,
  input  logic              io_ptw_req_ready,
  output logic [VPN_W-1:0]  io_ptw_req_bits_addr,
  input  logic              io_ptw_resp_valid,
  input  logic              io_ptw_resp_bits_error,
  input  logic              io_ptw_invalidate,
  output logic              refill_wen,
  output logic [IW-1:0]     refill_idx,
  output logic [TW-1:0]     refill_tag,
  output logic [ENTRIES-1:0] valid
);
  typedef enum logic [1:0] {READY, REQUEST, WAIT, WAIT_INV} state_t;
  state_t state;
  logic [ENTRIES-2:0] plru;
  logic [TW-1:0] r_tag;
  logic [IW-1:0] r_idx, victim, hit_idx;
  // Tree node n (root 1) lives at plru[n-1]; a set bit steers the walk right.
  function automatic logic [IW-1:0] tree_leaf(input logic [ENTRIES-2:0] t);
    int n;
    n = 1;
    for (int l = 0; l < IW; l++) n = 2 * n + int'(t[n-1]);
    return IW'(n - ENTRIES);
  endfunction
  function automatic logic [ENTRIES-2:0] touch(input logic [ENTRIES-2:0] t, input logic [IW-1:0] i);
    int n;
    n = 1;
    for (int l = IW - 1; l >= 0; l--) begin
      t[n-1] = ~i[l];
      n = 2 * n + int'(i[l]);
    end
    return t;
  endfunction
  always_comb begin
    victim = tree_leaf(plru);
    for (int k = ENTRIES - 1; k >= 0; k--) if (!valid[k]) victim = IW'(k);
  end
  always_comb begin
    hit_idx = '0;
    for (int k = 0; k < ENTRIES; k++) if (hits[k]) hit_idx = hit_idx | IW'(k);
  end
  assign io_req_ready = state == READY;
  assign io_ptw_req_valid = state == REQUEST;
  assign io_ptw_req_bits_addr = io_ptw_req_valid ? r_tag[VPN_W-1:0] : '0;
  assign refill_wen = state == WAIT && io_ptw_resp_valid && !io_ptw_resp_bits_error && !io_ptw_invalidate;
  assign refill_idx = refill_wen ? r_idx : '0;
  assign refill_tag = refill_wen ? r_tag : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= READY;
      valid <= '0;
      plru <= '0;
      r_tag <= '0;
      r_idx <= '0;
    end else begin
      case (state)
        READY:
          if (io_req_valid && tlb_miss) begin
            r_tag <= {io_ptw_ptbr_asid, io_req_bits_vpn};
            r_idx <= victim;
            state <= REQUEST;
          end else if (io_req_valid && |hits) plru <= touch(plru, hit_idx);
        REQUEST:
          if (io_ptw_invalidate) state <= READY;
          else if (io_ptw_req_ready) state <= WAIT;
        WAIT:
          if (io_ptw_resp_valid) begin
            state <= READY;
            if (io_ptw_resp_bits_error) valid[r_idx] <= 1'b0;
            else if (!io_ptw_invalidate) begin
              valid[r_idx] <= 1'b1;
              plru <= touch(plru, r_idx);
            end
          end else if (io_ptw_invalidate) state <= WAIT_INV;
        WAIT_INV:
          if (io_ptw_resp_valid) state <= READY;
        default: state <= READY;
      endcase
      if (io_ptw_invalidate) valid <= '0;
    end
  end
endmodule
